// File: rtl/mem_bank_cfg_writer_pkg.sv
// mem_bank_cfg_pkg: shared types, default timing and width helpers for the
// memory-bank configuration writer. MEM_BANK_CFG_PARITY_EN widens the
// row-word by one even-parity bit (see cfg_data_w).
package mem_bank_cfg_pkg;

    // Writer FSM states; the top keeps them in plain logic [2:0] registers.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_WORD = 3'd1,
        ST_SETUP     = 3'd2,
        ST_PULSE     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    // Default geometry and word-line timing.
    localparam int DEF_BL_WIDTH        = 40;
    localparam int DEF_WL_WIDTH        = 4;
    localparam int DEF_WL_SETUP_CYCLES = 1;
    localparam int DEF_WL_PULSE_CYCLES = 2;
    localparam int DEF_WL_HOLD_CYCLES  = 1;

    // Bits needed to index n values (clog2, never less than 1).
    function automatic int bits_for(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // Width of the row-word on the stream; parity builds carry an extra MSB.
    function automatic int cfg_data_w(input int bl_width);
`ifdef MEM_BANK_CFG_PARITY_EN
        return bl_width + 1;
`else
        return bl_width;
`endif
    endfunction

endpackage

// File: rtl/mem_bank_cfg_writer_if.sv
// mem_bank_cfg_writer_if: valid/ready row-word stream feeding the writer.
// With MEM_BANK_CFG_PARITY_EN defined, cfg_data carries an even-parity MSB.
interface mem_bank_cfg_writer_if
    import mem_bank_cfg_pkg::*;
#(
    parameter int BL_WIDTH = DEF_BL_WIDTH
);

    localparam int DATA_W = cfg_data_w(BL_WIDTH);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_last;

    // Word source side (fabric controller or testbench).
    modport master (
        output cfg_valid,
        output cfg_data,
        output cfg_last,
        input  cfg_ready
    );

    // Word sink side (the writer).
    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  cfg_last,
        output cfg_ready
    );

endinterface

// File: rtl/mem_bank_cfg_writer_timer.sv
// mem_bank_cfg_timer: loadable down-counter with a zero flag. One instance
// times the setup, pulse and hold phases of each row in turn.
module mem_bank_cfg_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load takes priority; otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_bank_cfg_writer.sv
// mem_bank_cfg_writer: drives bl/wl of a memory-bank configuration chain.
// Each accepted row-word is placed on bl, then the row's one-hot word line
// is pulsed with setup/pulse/hold timing. All outputs are registered.
// Optional MEM_BANK_CFG_PARITY_EN: rows with bad even parity are not written.
module mem_bank_cfg_writer
    import mem_bank_cfg_pkg::*;
#(
    parameter int BL_WIDTH        = DEF_BL_WIDTH,
    parameter int WL_WIDTH        = DEF_WL_WIDTH,
    parameter int WL_SETUP_CYCLES = DEF_WL_SETUP_CYCLES,
    parameter int WL_PULSE_CYCLES = DEF_WL_PULSE_CYCLES,
    parameter int WL_HOLD_CYCLES  = DEF_WL_HOLD_CYCLES
) (
    input  logic                prog_clk,
    input  logic                prog_rst_n,
    input  logic                start,
    mem_bank_cfg_writer_if.slave cfg,
    output logic [BL_WIDTH-1:0] bl,
    output logic [WL_WIDTH-1:0] wl,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_WAIT_WORD = ST_WAIT_WORD;
    localparam logic [2:0] S_SETUP     = ST_SETUP;
    localparam logic [2:0] S_PULSE     = ST_PULSE;
    localparam logic [2:0] S_HOLD      = ST_HOLD;
    localparam logic [2:0] S_DONE      = ST_DONE;

    localparam int ROW_W = bits_for(WL_WIDTH);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(WL_WIDTH - 1);

    localparam int T_SP   = (WL_SETUP_CYCLES > WL_PULSE_CYCLES) ? WL_SETUP_CYCLES : WL_PULSE_CYCLES;
    localparam int T_MAX  = (T_SP > WL_HOLD_CYCLES) ? T_SP : WL_HOLD_CYCLES;
    localparam int CNT_W  = bits_for(T_MAX);

    // Phase lengths are loaded as (cycles - 1) because the zero cycle counts.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(WL_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(WL_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(WL_HOLD_CYCLES - 1);

    logic [2:0]          state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                last_q, last_d;
    logic [BL_WIDTH-1:0] bl_q, bl_d;
    logic [WL_WIDTH-1:0] wl_q, wl_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_val;
    logic                tmr_zero;
    logic                handshake;
    logic                parity_bad;
    logic                row_is_max;

`ifdef MEM_BANK_CFG_PARITY_EN
    // Even parity over data plus parity bit must reduce to zero.
    assign parity_bad = ^cfg.cfg_data;
`else
    assign parity_bad = 1'b0;
`endif

    assign handshake  = cfg.cfg_valid && cfg_ready_q;
    assign row_is_max = (row_q == ROW_MAX);

    mem_bank_cfg_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (prog_clk),
        .rst_n    (prog_rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state logic; registered outputs are derived from the next state so
    // that wl/cfg_ready/busy/done line up exactly with the state they belong to.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        last_d   = last_q;
        bl_d     = bl_q;
        error_d  = error_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_WORD;
                    row_d   = '0;
                    error_d = 1'b0;
                end
            end

            S_WAIT_WORD: begin
                if (handshake) begin
                    bl_d     = cfg.cfg_data[BL_WIDTH-1:0];
                    last_d   = cfg.cfg_last;
                    tmr_load = 1'b1;
                    if (parity_bad) begin
                        // Corrupt row: keep wl low, still run the hold phase.
                        error_d = 1'b1;
                        tmr_val = HOLD_LD;
                        state_d = S_HOLD;
                    end else begin
                        tmr_val = SETUP_LD;
                        state_d = S_SETUP;
                    end
                end
            end

            S_SETUP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                    state_d  = S_PULSE;
                end
            end

            S_PULSE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                    state_d  = S_HOLD;
                end
            end

            S_HOLD: begin
                if (tmr_zero) begin
                    bl_d = '0;
                    if (last_q || row_is_max) begin
                        // Frame ends; last flag and final row must coincide.
                        if (last_q != row_is_max) begin
                            error_d = 1'b1;
                        end
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = S_WAIT_WORD;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        wl_d        = (state_d == S_PULSE) ? (WL_WIDTH'(1) << row_d) : '0;
        cfg_ready_d = (state_d == S_WAIT_WORD);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers; reset abandons any row in flight.
    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            last_q      <= 1'b0;
            bl_q        <= '0;
            wl_q        <= '0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            last_q      <= last_d;
            bl_q        <= bl_d;
            wl_q        <= wl_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign bl            = bl_q;
    assign wl            = wl_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_mem_bank_cfg_writer.sv
// tb_mem_bank_cfg_writer: directed and randomized frames for the memory-bank
// configuration writer, checked against a frame-level reference model.
module tb_mem_bank_cfg_writer;
    import mem_bank_cfg_pkg::*;

    localparam int BLW = 40;
    localparam int WLW = 4;
    localparam int SU  = 1;
    localparam int PW  = 2;
    localparam int HD  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [BLW-1:0] bl;
    logic [WLW-1:0] wl;
    logic busy, done, error;

    mem_bank_cfg_writer_if #(.BL_WIDTH(BLW)) ifc ();

    mem_bank_cfg_writer #(
        .BL_WIDTH(BLW), .WL_WIDTH(WLW),
        .WL_SETUP_CYCLES(SU), .WL_PULSE_CYCLES(PW), .WL_HOLD_CYCLES(HD)
    ) dut (
        .prog_clk   (clk),
        .prog_rst_n (rst_n),
        .start      (start),
        .cfg        (ifc),
        .bl         (bl),
        .wl         (wl),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        logic [WLW-1:0] w;
        logic [BLW-1:0] b;
        int             len;
        int             st;
    } pulse_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;
    pulse_t obs_q[$];
    pulse_t exp_q[$];
    int hs_q[$];
    logic [BLW-1:0] fw[4];
    bit fl[4];
    bit fb[4];
    logic [WLW-1:0] pw_w = '0;
    logic [BLW-1:0] pw_b = '0;
    int pw_len = 0;
    int pw_st = 0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: records every word-line pulse and checks invariants.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (done === 1'b1) done_cnt++;
            if (wl !== '0) begin
                chk("wl_onehot", 64'($onehot(wl)), 64'd1);
                if (wl === pw_w) begin
                    pw_len++;
                    chk("bl_stable_in_pulse", 64'(bl), 64'(pw_b));
                end else begin
                    if (pw_w !== '0) obs_q.push_back('{pw_w, pw_b, pw_len, pw_st});
                    pw_w = wl; pw_b = bl; pw_len = 1; pw_st = cyc;
                end
            end else if (pw_w !== '0) begin
                obs_q.push_back('{pw_w, pw_b, pw_len, pw_st});
                pw_w = '0;
            end
        end
    end

    function automatic logic [BLW-1:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[BLW-1:0];
    endfunction

    task automatic send_word(input logic [BLW-1:0] d, input bit l, input bit badp);
        int w = 0;
`ifdef MEM_BANK_CFG_PARITY_EN
        ifc.cfg_data = {(^d) ^ badp, d};
`else
        ifc.cfg_data = d;
        if (badp) $display("note: parity fault requested in a non-parity build");
`endif
        ifc.cfg_last  = l;
        ifc.cfg_valid = 1'b1;
        while (ifc.cfg_ready !== 1'b1 && w < 64) begin @(negedge clk); w++; end
        chk("handshake_wait", 64'(w < 64), 64'd1);
        hs_q.push_back(cyc);
        @(negedge clk);
        ifc.cfg_valid = 1'b0;
        ifc.cfg_last  = 1'b0;
    endtask

    task automatic begin_frame();
        obs_q.delete(); hs_q.delete(); done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("error_cleared_by_start", 64'(error), 64'd0);
        chk("ready_after_start", 64'(ifc.cfg_ready), 64'd1);
    endtask

    // Reference model: which rows get written, and whether the frame is faulty.
    task automatic end_frame(input int n);
        int w = 0;
        bit err = 1'b0;
        while (done !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        chk("done_seen", 64'(done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd1);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
        @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (fb[i]) err = 1'b1;
            else exp_q.push_back('{WLW'(1) << i, fw[i], PW, hs_q[i] + SU + 1});
            if (fl[i] || i == WLW - 1) begin
                if (fl[i] != (i == WLW - 1)) err = 1'b1;
                break;
            end
        end
        chk("pulse_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk("pulse_wl", 64'(obs_q[i].w), 64'(exp_q[i].w));
            chk("pulse_bl", 64'(obs_q[i].b), 64'(exp_q[i].b));
            chk("pulse_len", 64'(obs_q[i].len), 64'(exp_q[i].len));
            chk("pulse_start_time", 64'(obs_q[i].st), 64'(exp_q[i].st));
        end
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("error_flag", 64'(error), 64'(err));
    endtask

    task automatic run_frame(input int n, input bit gaps);
        begin_frame();
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(fw[i], fl[i], fb[i]);
        end
        end_frame(n);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 4; i++) begin fw[i] = rnd(); fl[i] = 1'b0; fb[i] = 1'b0; end
    endtask

    initial begin
        int w;
        bit acc;
        ifc.cfg_valid = 1'b0;
        ifc.cfg_last  = 1'b0;
        ifc.cfg_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bl", 64'(bl), 64'd0);
        chk("rst_wl", 64'(wl), 64'd0);
        chk("rst_ready", 64'(ifc.cfg_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Normal frame with the fixed words
        clear_frame();
        fw[0] = 40'h00000000FF; fw[1] = 40'h0F0F0F0F0F;
        fw[2] = 40'hAAAAAAAAAA; fw[3] = 40'h5555555555; fl[3] = 1'b1;
        run_frame(4, 1'b0);

        // Backpressure, with a stray start that must be ignored
        clear_frame(); fl[3] = 1'b1;
        begin_frame();
        send_word(fw[0], 1'b0, 1'b0);
        w = 0;
        while (ifc.cfg_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        chk("row_turnaround", 64'(cyc - hs_q[0]), 64'(SU + PW + HD + 1));
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(negedge clk);
            chk("bp_bl", 64'(bl), 64'd0);
            chk("bp_wl", 64'(wl), 64'd0);
            chk("bp_ready", 64'(ifc.cfg_ready), 64'd1);
        end
        start = 1'b0;
        for (int i = 1; i < 4; i++) send_word(fw[i], fl[i], fb[i]);
        end_frame(4);

        // Early last on word 2
        clear_frame(); fl[1] = 1'b1;
        run_frame(2, 1'b1);

        // Missing last, then a fifth word must not be accepted
        clear_frame();
        run_frame(4, 1'b0);
        ifc.cfg_data = '1;
        ifc.cfg_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); acc |= (ifc.cfg_ready === 1'b1); end
        ifc.cfg_valid = 1'b0;
        chk("fifth_word_refused", 64'(acc), 64'd0);
        chk("no_extra_pulse", 64'(obs_q.size()), 64'd4);

        // Reset in the middle of row 1's pulse
        clear_frame();
        begin_frame();
        send_word(fw[0], 1'b0, 1'b0);
        send_word(fw[1], 1'b0, 1'b0);
        w = 0;
        while (wl !== 4'b0010 && w < 20) begin @(negedge clk); w++; end
        chk("row1_pulse_seen", 64'(wl), 64'h2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_wl", 64'(wl), 64'd0);
        chk("midrst_bl", 64'(bl), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(ifc.cfg_ready), 64'd0);
        chk("midrst_error", 64'(error), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        clear_frame(); fl[3] = 1'b1;
        run_frame(4, 1'b0);

        // Randomized frames
        for (int k = 0; k < 8; k++) begin
            int len;
            clear_frame();
            len = $urandom_range(1, 4);
            if (len < 4) fl[len - 1] = 1'b1;
            else fl[3] = bit'($urandom_range(0, 1));
            run_frame(len, 1'b1);
        end

`ifdef MEM_BANK_CFG_PARITY_EN
        // Row 2 with a corrupted parity bit
        clear_frame(); fl[3] = 1'b1; fb[2] = 1'b1;
        run_frame(4, 1'b0);
        acc = 1'b0;
        foreach (obs_q[i]) acc |= (obs_q[i].w === 4'b0100);
        chk("parity_row_skipped", 64'(acc), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
